// File: rtl/remap_cache_fill_sched_if.sv
// Fill-line handshake from the DRAM read path plus the cache write (wad) port of the remap cache.
interface remap_cache_fill_sched_if #(
  parameter int N_ICFG  = 4,
  parameter int HBW     = 6,
  parameter int DBW     = 16,
  parameter int VSIZE   = 32,
  parameter int ICFG_BW = $clog2(N_ICFG + 1)
);
  logic                      fill_rdy;
  logic                      fill_ack;
  logic [ICFG_BW-1:0]        fill_id;
  logic [VSIZE-1:0][DBW-1:0] fill_data;
  logic                      wad_dval;
  logic [ICFG_BW-1:0]        wid;
  logic [HBW-1:0]            whiaddr;
  logic [VSIZE-1:0][DBW-1:0] wdata;

  modport master (
    output fill_rdy, fill_id, fill_data,
    input  fill_ack, wad_dval, wid, whiaddr, wdata
  );

  modport slave (
    input  fill_rdy, fill_id, fill_data,
    output fill_ack, wad_dval, wid, whiaddr, wdata
  );
endinterface

// File: rtl/remap_cache_fill_sched.sv
// Fill-side scheduler: maps tagged lines into per-config circular cache regions under line-credit control.
// Optional macro REMAP_FILL_STALL_CNT_EN adds o_stall_cnt, a saturating count of zero-credit stall cycles.
module remap_cache_fill_sched #(
  parameter int N_ICFG  = 4,
  parameter int HBW     = 6,
  parameter int DBW     = 16,
  parameter int VSIZE   = 32,
  parameter int ICFG_BW = $clog2(N_ICFG + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cfg_load,
  input  logic [N_ICFG-1:0][HBW-1:0] i_base,
  input  logic [N_ICFG-1:0][HBW:0]   i_nline,
  remap_cache_fill_sched_if.slave    fill_bus,
  input  logic                       i_free_dval,
  input  logic [ICFG_BW-1:0]         i_free_id,
  output logic [N_ICFG-1:0][HBW:0]   o_credit,
  output logic                       o_err
`ifdef REMAP_FILL_STALL_CNT_EN
  ,
  output logic [31:0]                o_stall_cnt
`endif
);
  localparam int IDX_BW = (N_ICFG > 1) ? $clog2(N_ICFG) : 1;

  logic [N_ICFG-1:0][HBW-1:0] base_r;
  logic [N_ICFG-1:0][HBW:0]   nline_r;
  logic [N_ICFG-1:0][HBW:0]   credit_r;
  logic [N_ICFG-1:0][HBW:0]   credit_nxt_s;
  logic [N_ICFG-1:0][HBW-1:0] wptr_r;
  logic                       err_r;
  logic                       wad_dval_r;
  logic [ICFG_BW-1:0]         wid_r;
  logic [HBW-1:0]             whiaddr_r;
  logic [VSIZE-1:0][DBW-1:0]  wdata_r;

  logic                       fill_id_ok_s;
  logic                       free_id_ok_s;
  logic [IDX_BW-1:0]          fill_idx_s;
  logic [IDX_BW-1:0]          free_idx_s;
  logic                       ack_s;
  logic                       wrap_s;
  logic                       fill_err_s;
  logic                       free_err_s;
  logic [N_ICFG-1:0]          inc_s;
  logic [N_ICFG-1:0]          dec_s;

  // Accept decision, error events and next-credit computation.
  always_comb begin
    fill_id_ok_s = (fill_bus.fill_id < ICFG_BW'(N_ICFG));
    free_id_ok_s = (i_free_id < ICFG_BW'(N_ICFG));
    fill_idx_s   = fill_bus.fill_id[IDX_BW-1:0];
    free_idx_s   = i_free_id[IDX_BW-1:0];
    ack_s        = fill_bus.fill_rdy && !i_cfg_load && fill_id_ok_s &&
                   (credit_r[fill_idx_s] != '0);
    wrap_s       = (({1'b0, wptr_r[fill_idx_s]} + (HBW+1)'(1)) == nline_r[fill_idx_s]);
    fill_err_s   = fill_bus.fill_rdy && !i_cfg_load &&
                   (!fill_id_ok_s || (nline_r[fill_idx_s] == '0));
    // A free matched by a same-id accept is a net no-op, never an overflow.
    free_err_s   = i_free_dval && !i_cfg_load &&
                   (!free_id_ok_s ||
                    ((credit_r[free_idx_s] == nline_r[free_idx_s]) &&
                     !(ack_s && (fill_idx_s == free_idx_s))));
    inc_s        = '0;
    dec_s        = '0;
    credit_nxt_s = credit_r;
    for (int k = 0; k < N_ICFG; k++) begin
      inc_s[k] = i_free_dval && free_id_ok_s && (free_idx_s == IDX_BW'(k));
      dec_s[k] = ack_s && (fill_idx_s == IDX_BW'(k));
      if (inc_s[k] && dec_s[k]) begin
        credit_nxt_s[k] = credit_r[k];
      end else if (dec_s[k]) begin
        credit_nxt_s[k] = credit_r[k] - (HBW+1)'(1);
      end else if (inc_s[k] && (credit_r[k] != nline_r[k])) begin
        credit_nxt_s[k] = credit_r[k] + (HBW+1)'(1);
      end else begin
        credit_nxt_s[k] = credit_r[k];
      end
    end
  end

  // Region table, write pointers, credits, sticky error and the registered write port.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      base_r     <= '0;
      nline_r    <= '0;
      credit_r   <= '0;
      wptr_r     <= '0;
      err_r      <= 1'b0;
      wad_dval_r <= 1'b0;
      wid_r      <= '0;
      whiaddr_r  <= '0;
      wdata_r    <= '0;
    end else if (i_cfg_load) begin
      base_r     <= i_base;
      nline_r    <= i_nline;
      credit_r   <= i_nline;
      wptr_r     <= '0;
      err_r      <= 1'b0;
      wad_dval_r <= 1'b0;
    end else begin
      wad_dval_r <= ack_s;
      credit_r   <= credit_nxt_s;
      if (ack_s) begin
        wid_r                <= fill_bus.fill_id;
        whiaddr_r            <= base_r[fill_idx_s] + wptr_r[fill_idx_s];
        wdata_r              <= fill_bus.fill_data;
        wptr_r[fill_idx_s]   <= wrap_s ? '0 : (wptr_r[fill_idx_s] + HBW'(1));
      end
      if (fill_err_s || free_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign fill_bus.fill_ack = ack_s;
  assign fill_bus.wad_dval = wad_dval_r;
  assign fill_bus.wid      = wid_r;
  assign fill_bus.whiaddr  = whiaddr_r;
  assign fill_bus.wdata    = wdata_r;
  assign o_credit          = credit_r;
  assign o_err             = err_r;

`ifdef REMAP_FILL_STALL_CNT_EN
  logic [31:0] stall_cnt_r;
  logic        stall_s;

  assign stall_s = fill_bus.fill_rdy && !i_cfg_load && fill_id_ok_s && (credit_r[fill_idx_s] == '0);

  // Saturating count of cycles a valid fill waits on an empty credit pool.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_cnt_r <= 32'd0;
    end else if (i_cfg_load) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_r;
`endif
endmodule

// File: tb/tb_remap_cache_fill_sched.sv
// Randomized plus directed bench for remap_cache_fill_sched against an array/arithmetic reference model.
module tb_remap_cache_fill_sched;
  localparam int NC = 4;

  logic              clk;
  logic              rst_n;
  logic              cfg_load;
  logic [NC-1:0][5:0] base;
  logic [NC-1:0][6:0] nline;
  logic              free_dval;
  logic [2:0]        free_id;
  logic [NC-1:0][6:0] credit;
  logic              err;
`ifdef REMAP_FILL_STALL_CNT_EN
  logic [31:0]       stall_cnt;
  longint            stall_m;
`endif

  remap_cache_fill_sched_if #(.N_ICFG(NC), .HBW(6), .DBW(16), .VSIZE(32)) bus ();

  remap_cache_fill_sched #(.N_ICFG(NC), .HBW(6), .DBW(16), .VSIZE(32)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_cfg_load (cfg_load),
    .i_base     (base),
    .i_nline    (nline),
    .fill_bus   (bus),
    .i_free_dval(free_dval),
    .i_free_id  (free_id),
    .o_credit   (credit),
    .o_err      (err)
`ifdef REMAP_FILL_STALL_CNT_EN
    ,
    .o_stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model state
  int           base_m[NC];
  int           nline_m[NC];
  int           credit_m[NC];
  int           wptr_m[NC];
  bit           err_m;
  bit           exp_dval;
  int           exp_wid;
  int           exp_whiaddr;
  logic [511:0] exp_wdata;
  bit           last_ack_m;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      base_m[k] = 0; nline_m[k] = 0; credit_m[k] = 0; wptr_m[k] = 0;
    end
    err_m = 0; exp_dval = 0; exp_wid = 0; exp_whiaddr = 0; exp_wdata = '0; last_ack_m = 0;
`ifdef REMAP_FILL_STALL_CNT_EN
    stall_m = 0;
`endif
  endtask

  function automatic bit model_ack();
    int id;
    id = int'(bus.fill_id);
    if (!bus.fill_rdy || cfg_load || id >= NC) return 1'b0;
    return credit_m[id] != 0;
  endfunction

  // One clock: compare DUT against the model, advance the model, then move to the next low phase.
  task automatic cycle();
    bit a;
    int id;
    int fid;
    #1;
    a  = model_ack();
    id = int'(bus.fill_id);
    fid = int'(free_id);
    chk("fill_ack", 512'(bus.fill_ack), 512'(a));
    chk("wad_dval", 512'(bus.wad_dval), 512'(exp_dval));
    if (exp_dval) begin
      chk("wid", 512'(bus.wid), 512'(exp_wid));
      chk("whiaddr", 512'(bus.whiaddr), 512'(exp_whiaddr));
      chk("wdata", 512'(bus.wdata), exp_wdata);
    end
    for (int k = 0; k < NC; k++) chk($sformatf("credit%0d", k), 512'(credit[k]), 512'(credit_m[k]));
    chk("err", 512'(err), 512'(err_m));
`ifdef REMAP_FILL_STALL_CNT_EN
    chk("stall_cnt", 512'(stall_cnt), 512'(stall_m));
`endif
    if (!rst_n) begin
      model_reset();
    end else if (cfg_load) begin
      for (int k = 0; k < NC; k++) begin
        base_m[k] = int'(base[k]); nline_m[k] = int'(nline[k]);
        credit_m[k] = nline_m[k]; wptr_m[k] = 0;
      end
      err_m = 0; exp_dval = 0;
`ifdef REMAP_FILL_STALL_CNT_EN
      stall_m = 0;
`endif
    end else begin
`ifdef REMAP_FILL_STALL_CNT_EN
      if (bus.fill_rdy && id < NC && credit_m[id % NC] == 0 && stall_m < 64'hFFFF_FFFF) stall_m++;
`endif
      exp_dval = a;
      if (a) begin
        exp_wid     = id;
        exp_whiaddr = (base_m[id] + wptr_m[id]) % 64;
        exp_wdata   = bus.fill_data;
        wptr_m[id]  = (wptr_m[id] + 1) % nline_m[id];
      end
      if (bus.fill_rdy && (id >= NC || nline_m[id % NC] == 0)) err_m = 1;
      if (free_dval) begin
        if (fid >= NC) err_m = 1;
        else if (a && fid == id) ;
        else if (credit_m[fid] == nline_m[fid]) err_m = 1;
        else credit_m[fid]++;
      end
      if (a && !(free_dval && fid == id)) credit_m[id]--;
    end
    last_ack_m = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_cfg(input int b[NC], input int n[NC]);
    for (int k = 0; k < NC; k++) begin
      base[k] = 6'(b[k]); nline[k] = 7'(n[k]);
    end
    cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0;
  endtask

  task automatic fills(input int id, input int cnt);
    bus.fill_rdy = 1'b1; bus.fill_id = 3'(id);
    for (int i = 0; i < cnt; i++) begin
      bus.fill_data = rand_line();
      cycle();
    end
    bus.fill_rdy = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; cfg_load = 1'b0; base = '0; nline = '0; free_dval = 1'b0; free_id = '0;
    bus.fill_rdy = 1'b0; bus.fill_id = '0; bus.fill_data = '0;
    model_reset();
    @(negedge clk);
    cycle();
    chk("rst_whiaddr", 512'(bus.whiaddr), 512'd0);
    chk("rst_wid", 512'(bus.wid), 512'd0);
    chk("rst_wdata", 512'(bus.wdata), 512'd0);
    rst_n = 1'b1;
    cycle();

    // Region fill of id1 to exhaustion, 17th held
    load_cfg('{0, 16, 32, 48}, '{16, 16, 16, 16});
    bus.fill_rdy = 1'b1; bus.fill_id = 3'd1;
    for (int i = 0; i < 16; i++) begin
      bus.fill_data = rand_line();
      cycle();
    end
    bus.fill_data = rand_line();
    #1;
    chk("t1_last_whiaddr", 512'(bus.whiaddr), 512'd31);
    chk("t1_credit1", 512'(credit[1]), 512'd0);
    chk("t1_17th_ack", 512'(bus.fill_ack), 512'd0);

    // Free one line of id1 while the fill waits; it wraps to the region start
    free_dval = 1'b1; free_id = 3'd1;
    cycle();
    free_dval = 1'b0;
    #1;
    chk("t2_credit1", 512'(credit[1]), 512'd1);
    chk("t2_ack", 512'(bus.fill_ack), 512'd1);
    cycle();
    bus.fill_rdy = 1'b0;
    chk("t2_whiaddr_wrap", 512'(bus.whiaddr), 512'd16);
    chk("t2_credit1_after", 512'(credit[1]), 512'd0);

    // Simultaneous ack/free on the same id and on different ids
    fills(2, 11);
    bus.fill_rdy = 1'b1; bus.fill_id = 3'd2; bus.fill_data = rand_line();
    free_dval = 1'b1; free_id = 3'd2;
    cycle();
    bus.fill_rdy = 1'b0; free_dval = 1'b0;
    chk("t3_credit2_same", 512'(credit[2]), 512'd5);
    fills(3, 1);
    bus.fill_rdy = 1'b1; bus.fill_id = 3'd0; bus.fill_data = rand_line();
    free_dval = 1'b1; free_id = 3'd3;
    cycle();
    bus.fill_rdy = 1'b0; free_dval = 1'b0;
    chk("t3_credit0", 512'(credit[0]), 512'd15);
    chk("t3_credit3", 512'(credit[3]), 512'd16);
    chk("t3_err_clear", 512'(err), 512'd0);

    // Unused config and credit overflow errors
    load_cfg('{0, 16, 32, 48}, '{16, 16, 16, 0});
    bus.fill_rdy = 1'b1; bus.fill_id = 3'd3; bus.fill_data = rand_line();
    cycle(); cycle(); cycle();
    #1;
    chk("t4_unused_ack", 512'(bus.fill_ack), 512'd0);
    chk("t4_unused_err", 512'(err), 512'd1);
    bus.fill_rdy = 1'b0;
    load_cfg('{0, 16, 32, 48}, '{16, 16, 16, 16});
    chk("t4_err_cleared", 512'(err), 512'd0);
    free_dval = 1'b1; free_id = 3'd0;
    cycle();
    free_dval = 1'b0;
    chk("t4_ovf_err", 512'(err), 512'd1);
    chk("t4_ovf_credit0", 512'(credit[0]), 512'd16);

    // Async reset while a write is about to be registered
    load_cfg('{0, 16, 32, 48}, '{16, 16, 16, 16});
    fills(0, 13);
    chk("t5_credit0", 512'(credit[0]), 512'd3);
    bus.fill_rdy = 1'b1; bus.fill_id = 3'd0; bus.fill_data = rand_line();
    #1;
    chk("t5_ack_before_rst", 512'(bus.fill_ack), 512'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    cycle();
    chk("t5_no_wad", 512'(bus.wad_dval), 512'd0);
    chk("t5_credit0_rst", 512'(credit[0]), 512'd0);
    bus.fill_rdy = 1'b0;
    rst_n = 1'b1;
    cycle();

`ifdef REMAP_FILL_STALL_CNT_EN
    load_cfg('{0, 16, 32, 48}, '{0, 0, 0, 0});
    bus.fill_rdy = 1'b1; bus.fill_id = 3'd0;
    for (int i = 0; i < 10; i++) cycle();
    bus.fill_rdy = 1'b0;
    chk("stall_10", 512'(stall_cnt), 512'd10);
    load_cfg('{0, 16, 32, 48}, '{16, 16, 16, 16});
    chk("stall_clear", 512'(stall_cnt), 512'd0);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (last_ack_m || !bus.fill_rdy || $urandom_range(0, 15) == 0) begin
        bus.fill_rdy  = ($urandom_range(0, 3) != 0);
        bus.fill_id   = 3'($urandom_range(0, 5));
        bus.fill_data = rand_line();
      end
      cfg_load = (n == 0) || ($urandom_range(0, 199) == 0);
      if (cfg_load) begin
        for (int k = 0; k < NC; k++) begin
          base[k]  = 6'($urandom_range(0, 63));
          nline[k] = ($urandom_range(0, 7) == 0) ? 7'd64 : 7'($urandom_range(0, 16));
        end
      end
      free_dval = ($urandom_range(0, 2) == 0);
      free_id   = 3'($urandom_range(0, 4));
      cycle();
    end
    cfg_load = 1'b0; free_dval = 1'b0; bus.fill_rdy = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
